// File: rtl/video_pkg.sv
// Shared video constants: default 800x600@60 timing (horizontal in 8-pixel units),
// counter width and the 6-bit RGB222 colour type.
package video_pkg;

  localparam int DEF_H_VISIBLE    = 100;
  localparam int DEF_H_FRONT      = 5;
  localparam int DEF_H_SYNC       = 16;
  localparam int DEF_H_BACK       = 11;
  localparam int DEF_V_VISIBLE    = 600;
  localparam int DEF_V_FRONT      = 1;
  localparam int DEF_V_SYNC       = 4;
  localparam int DEF_V_BACK       = 23;
  localparam int DEF_COUNTER_BITS = 11;

  typedef logic [5:0] colour_t;

  localparam colour_t COLOUR_BLACK = '0;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter with visible / front porch / sync / back porch
// regions decoded combinationally from the current count.
module vga_axis_counter #(
  parameter int VISIBLE = 100,
  parameter int FRONT   = 5,
  parameter int SYNC    = 16,
  parameter int BACK    = 11,
  parameter int WIDTH   = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             cnt_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             visible_o
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] VIS_END    = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] SYNC_START = WIDTH'(VISIBLE + FRONT);
  localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(VISIBLE + FRONT + SYNC);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (cnt_en_i) begin
      count_d = wrap_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign wrap_o    = (count_q == LAST);
  assign sync_o    = (count_q >= SYNC_START) && (count_q < SYNC_END);
  assign visible_o = (count_q < VIS_END);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing generator: horizontal and vertical axis counters plus one output register
// stage so syncs, colour, coordinates and pulses all carry the same single-cycle latency.
module vga_timing_generator
  import video_pkg::*;
#(
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int COUNTER_BITS = DEF_COUNTER_BITS
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    enable,
  input  logic [5:0]              pixel_in,
  output logic [5:0]              vga_pixel,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [COUNTER_BITS-1:0] pixel_x,
  output logic [COUNTER_BITS-1:0] pixel_y,
  output logic                    visible,
  output logic                    line_start,
  output logic                    frame_start
);

  logic [COUNTER_BITS-1:0] h_count, v_count;
  logic h_wrap, h_sync, h_vis;
  logic v_wrap_unused, v_sync, v_vis;
  logic clear;

  // Dropping enable clears both counters, so re-enabling always starts at h=0, v=0.
  assign clear = ~enable;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .WIDTH(COUNTER_BITS)
  ) u_h_axis (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (clear),
    .cnt_en_i (1'b1),
    .count_o  (h_count),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .visible_o(h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .WIDTH(COUNTER_BITS)
  ) u_v_axis (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (clear),
    .cnt_en_i (h_wrap),
    .count_o  (v_count),
    .wrap_o   (v_wrap_unused),
    .sync_o   (v_sync),
    .visible_o(v_vis)
  );

  logic                    hsync_d, vsync_d, visible_d, line_start_d, frame_start_d;
  logic                    hsync_q, vsync_q, visible_q, line_start_q, frame_start_q;
  colour_t                 pixel_d, pixel_q;
  logic [COUNTER_BITS-1:0] x_d, y_d, x_q, y_q;

  always_comb begin
    hsync_d       = ~h_sync;
    vsync_d       = ~v_sync;
    visible_d     = h_vis & v_vis;
    pixel_d       = visible_d ? colour_t'(pixel_in) : COLOUR_BLACK;
    x_d           = h_count;
    y_d           = v_count;
    line_start_d  = (h_count == '0);
    frame_start_d = line_start_d && (v_count == '0);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !enable) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      visible_q     <= 1'b0;
      pixel_q       <= COLOUR_BLACK;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      pixel_q       <= pixel_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign visible     = visible_q;
  assign vga_pixel   = pixel_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default horizontal timing, shortened vertical timing so
// whole frames fit in a short run; time-based reference model feeds a per-cycle scoreboard.
`timescale 1ns/1ps
module tb_vga_timing_generator;

  localparam int HV = 100, HF = 5, HS = 16, HB = 11;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 3, VB = 4;
  localparam int VT = VV + VF + VS + VB;
  localparam int CB = 11;
  localparam int CLK_NS = 25;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          enable;
  logic [5:0]    pixel_in;
  logic [5:0]    vga_pixel;
  logic          vga_hsync, vga_vsync;
  logic [CB-1:0] pixel_x, pixel_y;
  logic          visible, line_start, frame_start;

  always #12.5 wb_clk_i = ~wb_clk_i;

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COUNTER_BITS(CB)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .enable     (enable),
    .pixel_in   (pixel_in),
    .vga_pixel  (vga_pixel),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .visible    (visible),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic [5:0]    pix;
    logic          hs;
    logic          vs;
    logic [CB-1:0] x;
    logic [CB-1:0] y;
    logic          vis;
    logic          ls;
    logic          fs;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   run_t = 0;
  int   en_cyc;

  int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$], ls_at[$];

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected outputs after `tt` enabled cycles: position is simply elapsed time modulo totals.
  function automatic obs_t model_at(int tt, logic [5:0] pin);
    obs_t o;
    int h, v;
    h = tt % HT;
    v = (tt / HT) % VT;
    o.vis = (h < HV) && (v < VV);
    o.pix = o.vis ? pin : 6'h00;
    o.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    o.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    o.x   = CB'(h);
    o.y   = CB'(v);
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic check(string name, int got, int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  function automatic int at(ref int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1000000;
  endfunction

  task automatic clear_meas();
    hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
    fs_at.delete(); ls_at.delete();
  endtask

  // Reference: sample inputs at each edge and push the response the DUT must show after it.
  initial begin
    forever begin
      @(posedge wb_clk_i);
      cyc++;
      if (wb_rst_i !== 1'b0 || enable !== 1'b1) begin
        exp_q.push_back(reset_obs());
        run_t = 0;
      end else begin
        exp_q.push_back(model_at(run_t, pixel_in));
        run_t++;
      end
    end
  end

  // Monitor: compare every presented output cycle and log sync/pulse edges for timing checks.
  initial begin
    obs_t act, e;
    logic prev_hs, prev_vs;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    forever begin
      @(posedge wb_clk_i);
      #1;
      act = '{pix: vga_pixel, hs: vga_hsync, vs: vga_vsync, x: pixel_x, y: pixel_y,
              vis: visible, ls: line_start, fs: frame_start};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty cyc=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d got pix=%h hs=%b vs=%b x=%0d y=%0d vis=%b ls=%b fs=%b required pix=%h hs=%b vs=%b x=%0d y=%0d vis=%b ls=%b fs=%b",
                   cyc, act.pix, act.hs, act.vs, act.x, act.y, act.vis, act.ls, act.fs,
                   e.pix, e.hs, e.vs, e.x, e.y, e.vis, e.ls, e.fs);
        end
      end
      if (prev_hs === 1'b1 && vga_hsync === 1'b0) hs_fall.push_back(cyc);
      if (prev_hs === 1'b0 && vga_hsync === 1'b1) hs_rise.push_back(cyc);
      if (prev_vs === 1'b1 && vga_vsync === 1'b0) vs_fall.push_back(cyc);
      if (prev_vs === 1'b0 && vga_vsync === 1'b1) vs_rise.push_back(cyc);
      if (frame_start === 1'b1) fs_at.push_back(cyc);
      if (line_start === 1'b1) ls_at.push_back(cyc);
      prev_hs = vga_hsync;
      prev_vs = vga_vsync;
    end
  end

  task automatic check_hsync_restart(string tag);
    check({tag, "_first_hs_fall_clocks"}, at(hs_fall, 0) - en_cyc, HV + HF);
    check({tag, "_hs_low_ns"}, (at(hs_rise, 0) - at(hs_fall, 0)) * CLK_NS, HS * CLK_NS);
    check({tag, "_hs_period_ns"}, (at(hs_fall, 1) - at(hs_fall, 0)) * CLK_NS, HT * CLK_NS);
  endtask

  initial begin
    int n, lines, f0, f1;
    wb_rst_i = 1'b1;
    enable   = 1'b0;
    pixel_in = 6'h3F;
    repeat (3) @(negedge wb_clk_i);
    check("rst_hsync", int'(vga_hsync), 1);
    check("rst_vsync", int'(vga_vsync), 1);
    check("rst_pixel", int'(vga_pixel), 0);
    check("rst_x", int'(pixel_x), 0);
    check("rst_y", int'(pixel_y), 0);
    check("rst_pulses", int'({visible, line_start, frame_start}), 0);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);

    // Two full frames with colour held at full white.
    clear_meas();
    enable = 1'b1;
    en_cyc = cyc + 1;
    repeat (2 * VT * HT + 200) @(negedge wb_clk_i);
    check_hsync_restart("run");
    check("first_vs_fall_clocks", at(vs_fall, 0) - en_cyc, (VV + VF) * HT);
    check("vs_low_ns", (at(vs_rise, 0) - at(vs_fall, 0)) * CLK_NS, VS * HT * CLK_NS);
    check("vs_period_ns", (at(vs_fall, 1) - at(vs_fall, 0)) * CLK_NS, VT * HT * CLK_NS);
    check("fs_first_clocks", at(fs_at, 0) - en_cyc, 0);
    check("fs_period_clocks", at(fs_at, 1) - at(fs_at, 0), VT * HT);
    check("fs_count", fs_at.size(), 3);
    f0 = at(fs_at, 0);
    f1 = at(fs_at, 1);
    lines = 0;
    foreach (ls_at[i]) if (ls_at[i] >= f0 && ls_at[i] < f1) lines++;
    check("ls_per_frame", lines, VT);

    // Reset in the middle of a frame.
    n = 0;
    while (!(pixel_y == CB'(7) && pixel_x == CB'(40)) && n < 2 * VT * HT) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("reach_mid_frame_y", int'(pixel_y), 7);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_hsync", int'(vga_hsync), 1);
    check("midrst_vsync", int'(vga_vsync), 1);
    check("midrst_pixel", int'(vga_pixel), 0);
    check("midrst_xy", int'({pixel_x, pixel_y}), 0);
    clear_meas();
    wb_rst_i = 1'b0;
    en_cyc = cyc + 1;
    repeat (2 * HT + 40) @(negedge wb_clk_i);
    check_hsync_restart("midrst");
    check("midrst_fs_first", at(fs_at, 0) - en_cyc, 0);

    // Drop enable while hsync is low.
    n = 0;
    while (vga_hsync !== 1'b0 && n < 2 * HT) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("reach_hsync_low", int'(vga_hsync), 0);
    repeat (4) @(negedge wb_clk_i);
    enable = 1'b0;
    @(negedge wb_clk_i);
    check("disable_hsync_high", int'(vga_hsync), 1);
    repeat (2) @(negedge wb_clk_i);
    clear_meas();
    enable = 1'b1;
    en_cyc = cyc + 1;
    repeat (2 * HT + 40) @(negedge wb_clk_i);
    check_hsync_restart("reenable");

    // Random colour with occasional enable drops and resets; scoreboard checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      pixel_in = 6'($urandom);
      enable   = ($urandom_range(0, 199) != 0);
      wb_rst_i = ($urandom_range(0, 599) == 0);
      @(negedge wb_clk_i);
    end
    wb_rst_i = 1'b0;
    enable   = 1'b1;
    repeat (3) @(negedge wb_clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
